// File: rtl/snake_motion.sv
`timescale 1ns/1ps
// snake_motion
//   Movement engine for the snake. Holds the per-segment coordinate arrays
//   and segment count read by the body-display stage. Once per game tick it
//   shifts the body down one slot, advances the head one square in the
//   latched direction and applies any pending growth. A wall or self
//   collision freezes the snake in the DEAD state until start is pulsed.
//
// Ports
//   clk_25        in   25 MHz pixel clock
//   reset_game_n  in   asynchronous active-low reset, forces IDLE + init values
//   start         in   pulse: IDLE -> RUN, DEAD -> IDLE (re-initialise)
//   move_tick     in   one-cycle pulse per game step
//   dir_valid     in   qualifies dir_req
//   dir_req       in   requested direction: 0 up, 1 right, 2 down, 3 left
//   grow          in   one-cycle pulse, food eaten
//   snake_x       out  segment x coordinates, index 0 = head
//   snake_y       out  segment y coordinates, index 0 = head
//   snake_length  out  index of the last valid segment (count - 1)
//   game_over     out  high in DEAD
//   running       out  high in RUN
module snake_motion #(
    parameter int MAX_SNAKE_LENGTH  = 16,
    parameter int SNAKE_POS_SIZE    = 10,
    parameter int SNAKE_SQUARE_SIZE = 16,
    parameter int X_MIN             = 160,
    parameter int X_MAX             = 768,
    parameter int Y_MIN             = 48,
    parameter int Y_MAX             = 512,
    parameter int INIT_X            = 400,
    parameter int INIT_Y            = 256,
    parameter int INIT_LEN          = 3
) (
    input  logic                                 clk_25,
    input  logic                                 reset_game_n,
    input  logic                                 start,
    input  logic                                 move_tick,
    input  logic                                 dir_valid,
    input  logic [1:0]                           dir_req,
    input  logic                                 grow,
    output logic [SNAKE_POS_SIZE-1:0]            snake_x [MAX_SNAKE_LENGTH],
    output logic [SNAKE_POS_SIZE-1:0]            snake_y [MAX_SNAKE_LENGTH],
    output logic [$clog2(MAX_SNAKE_LENGTH)-1:0]  snake_length,
    output logic                                 game_over,
    output logic                                 running
);

    localparam int LEN_W = $clog2(MAX_SNAKE_LENGTH);
    localparam int P     = SNAKE_POS_SIZE;

    // One extra bit so a step below zero shows up as a negative value.
    typedef logic signed [P:0] coord_s_t;

    localparam coord_s_t STEP  = coord_s_t'(SNAKE_SQUARE_SIZE);
    localparam coord_s_t XMIN_S = coord_s_t'(X_MIN);
    localparam coord_s_t XMAX_S = coord_s_t'(X_MAX);
    localparam coord_s_t YMIN_S = coord_s_t'(Y_MIN);
    localparam coord_s_t YMAX_S = coord_s_t'(Y_MAX);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_SNAKE_LENGTH - 1);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    state_t           state;
    state_t           state_next;
    dir_t             dir;
    dir_t             pending_dir;
    dir_t             req_dir;
    dir_t             eff_dir;
    logic             grow_pending;

    logic             dir_legal;
    logic             grow_eff;
    logic             grow_apply;
    coord_s_t         head_xs;
    coord_s_t         head_ys;
    coord_s_t         next_xs;
    coord_s_t         next_ys;
    logic             wall_hit;
    logic             self_hit;
    logic [31:0]      len_u;
    logic             move_ok;
    logic             reinit;

    function automatic logic [P-1:0] init_x(input int unsigned i);
        if (i < INIT_LEN)
            return P'(INIT_X - int'(i) * SNAKE_SQUARE_SIZE);
        else
            return '0;
    endfunction

    function automatic logic [P-1:0] init_y(input int unsigned i);
        if (i < INIT_LEN)
            return P'(INIT_Y);
        else
            return '0;
    endfunction

    // Opposite direction: up<->down, right<->left differ only in bit 1.
    function automatic dir_t reverse_of(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // ------------------------------------------------------------------
    // Move evaluation and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        req_dir    = dir_t'(dir_req);
        dir_legal  = dir_valid && (req_dir != reverse_of(dir));
        // A legal request arriving with the tick steers that same move.
        eff_dir    = dir_legal ? req_dir : pending_dir;
        grow_eff   = grow_pending | grow;
        grow_apply = grow_eff && (snake_length < LEN_MAX);

        head_xs = {1'b0, snake_x[0]};
        head_ys = {1'b0, snake_y[0]};
        next_xs = head_xs;
        next_ys = head_ys;
        case (eff_dir)
            UP:      next_ys = head_ys - STEP;
            RIGHT:   next_xs = head_xs + STEP;
            DOWN:    next_ys = head_ys + STEP;
            LEFT:    next_xs = head_xs - STEP;
            default: ;
        endcase

        wall_hit = (next_xs < XMIN_S) || (next_xs > XMAX_S) ||
                   (next_ys < YMIN_S) || (next_ys > YMAX_S);

        // The tail slot moves away on a normal step, so it only counts as
        // an obstacle when growth keeps it in place.
        len_u    = 32'(snake_length);
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_SNAKE_LENGTH; i++) begin
            if ((i < len_u) || ((i == len_u) && grow_apply)) begin
                if ((snake_x[i] == next_xs[P-1:0]) &&
                    (snake_y[i] == next_ys[P-1:0]))
                    self_hit = 1'b1;
            end
        end

        state_next = state;
        move_ok    = 1'b0;
        reinit     = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                if (move_tick) begin
                    if (wall_hit || self_hit)
                        state_next = DEAD;
                    else
                        move_ok = 1'b1;
                end
            end
            DEAD: begin
                if (start) begin
                    state_next = IDLE;
                    reinit     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, body arrays and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25 or negedge reset_game_n) begin
        if (!reset_game_n) begin
            state        <= IDLE;
            running      <= 1'b0;
            game_over    <= 1'b0;
            for (int unsigned i = 0; i < MAX_SNAKE_LENGTH; i++) begin
                snake_x[i] <= init_x(i);
                snake_y[i] <= init_y(i);
            end
            snake_length <= LEN_INIT;
            dir          <= RIGHT;
            pending_dir  <= RIGHT;
            grow_pending <= 1'b0;
        end else begin
            state     <= state_next;
            running   <= (state_next == RUN);
            game_over <= (state_next == DEAD);

            if (reinit) begin
                for (int unsigned i = 0; i < MAX_SNAKE_LENGTH; i++) begin
                    snake_x[i] <= init_x(i);
                    snake_y[i] <= init_y(i);
                end
                snake_length <= LEN_INIT;
                dir          <= RIGHT;
                pending_dir  <= RIGHT;
                grow_pending <= 1'b0;
            end else if (state == RUN) begin
                if (move_ok) begin
                    // Shift copies the old tail into index len+1, so growth
                    // only needs the length bump.
                    for (int unsigned i = 1; i < MAX_SNAKE_LENGTH; i++) begin
                        snake_x[i] <= snake_x[i-1];
                        snake_y[i] <= snake_y[i-1];
                    end
                    snake_x[0] <= next_xs[P-1:0];
                    snake_y[0] <= next_ys[P-1:0];
                    if (grow_apply)
                        snake_length <= snake_length + 1'b1;
                    dir          <= eff_dir;
                    pending_dir  <= eff_dir;
                    grow_pending <= 1'b0;
                end else if (!move_tick) begin
                    if (dir_legal)
                        pending_dir <= req_dir;
                    if (grow)
                        grow_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_motion.sv
`timescale 1ns/1ps
// Bench for snake_motion: directed vector table, hand-written corner-case
// sequences and a randomized run, all checked against a queue-based model
// of the snake.
module tb_snake_motion;

    localparam int MAXL = 16;
    localparam int PW   = 10;

    logic            clk_25;
    logic            reset_game_n;
    logic            start;
    logic            move_tick;
    logic            dir_valid;
    logic [1:0]      dir_req;
    logic            grow;
    logic [PW-1:0]   snake_x [MAXL];
    logic [PW-1:0]   snake_y [MAXL];
    logic [3:0]      snake_length;
    logic            game_over;
    logic            running;

    snake_motion #(
        .MAX_SNAKE_LENGTH (16),
        .SNAKE_POS_SIZE   (10),
        .SNAKE_SQUARE_SIZE(16),
        .X_MIN            (160),
        .X_MAX            (768),
        .Y_MIN            (48),
        .Y_MAX            (512),
        .INIT_X           (400),
        .INIT_Y           (256),
        .INIT_LEN         (3)
    ) dut (
        .clk_25      (clk_25),
        .reset_game_n(reset_game_n),
        .start       (start),
        .move_tick   (move_tick),
        .dir_valid   (dir_valid),
        .dir_req     (dir_req),
        .grow        (grow),
        .snake_x     (snake_x),
        .snake_y     (snake_y),
        .snake_length(snake_length),
        .game_over   (game_over),
        .running     (running)
    );

    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int bx[$];
    int by[$];
    int mstate;   // 0 idle, 1 run, 2 dead
    int mdir;
    int mpend;
    bit mgrow;

    task automatic model_init();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(400 - 16 * i);
            by.push_back(256);
        end
        mstate = 0;
        mdir   = 1;
        mpend  = 1;
        mgrow  = 0;
    endtask

    task automatic model_step(input bit s, input bit mt, input bit dv,
                              input int dr, input bit g);
        int  ndir, nx, ny, lim;
        bit  legal, grows, hit;
        case (mstate)
            0: if (s) mstate = 1;
            1: begin
                legal = dv && (dr != (mdir + 2) % 4);
                ndir  = legal ? dr : mpend;
                if (mt) begin
                    nx = bx[0] + ((ndir == 1) ? 16 : (ndir == 3) ? -16 : 0);
                    ny = by[0] + ((ndir == 2) ? 16 : (ndir == 0) ? -16 : 0);
                    grows = (mgrow || g) && (bx.size() < MAXL);
                    hit = (nx < 160) || (nx > 768) || (ny < 48) || (ny > 512);
                    lim = grows ? bx.size() : bx.size() - 1;
                    for (int k = 0; k < lim; k++)
                        if (bx[k] == nx && by[k] == ny) hit = 1;
                    if (hit) begin
                        mstate = 2;
                    end else begin
                        bx.push_front(nx);
                        by.push_front(ny);
                        if (!grows) begin
                            void'(bx.pop_back());
                            void'(by.pop_back());
                        end
                        mdir  = ndir;
                        mpend = ndir;
                        mgrow = 0;
                    end
                end else begin
                    if (legal) mpend = dr;
                    if (g) mgrow = 1;
                end
            end
            default: if (s) model_init();
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model.len", 32'(snake_length), bx.size() - 1);
        check("model.game_over", 32'(game_over), (mstate == 2) ? 1 : 0);
        check("model.running", 32'(running), (mstate == 1) ? 1 : 0);
        for (int k = 0; k < bx.size(); k++) begin
            check($sformatf("model.x[%0d]", k), 32'(snake_x[k]), bx[k]);
            check($sformatf("model.y[%0d]", k), 32'(snake_y[k]), by[k]);
        end
    endtask

    task automatic cycle(input bit s, input bit mt, input bit dv,
                         input logic [1:0] dr, input bit g);
        start     = s;
        move_tick = mt;
        dir_valid = dv;
        dir_req   = dr;
        grow      = g;
        @(posedge clk_25);
        model_step(s, mt, dv, int'(dr), g);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        start = 0; move_tick = 0; dir_valid = 0; dir_req = 0; grow = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        idle_inputs();
        reset_game_n = 1'b0;
        model_init();
        #5;
        check("reset.head_x", 32'(snake_x[0]), 400);
        check("reset.seg2_x", 32'(snake_x[2]), 368);
        check("reset.len", 32'(snake_length), 2);
        check("reset.running", 32'(running), 0);
        #5;
        reset_game_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         s, mt, dv;
        logic [1:0] dr;
        bit         g;
        int         hx, hy, len;
        bit         go, run;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //        s  mt dv dr g   hx   hy  len go run
        vecs[0]  = '{0, 1, 0, 0, 0, 400, 256, 2, 0, 0}; // tick in IDLE ignored
        vecs[1]  = '{1, 0, 0, 0, 0, 400, 256, 2, 0, 1}; // start
        vecs[2]  = '{0, 1, 0, 0, 0, 416, 256, 2, 0, 1}; // first move right
        vecs[3]  = '{0, 1, 0, 0, 1, 432, 256, 3, 0, 1}; // grow with tick
        vecs[4]  = '{0, 1, 1, 3, 0, 448, 256, 3, 0, 1}; // left = reversal
        vecs[5]  = '{0, 1, 1, 0, 0, 448, 240, 3, 0, 1}; // up with tick
        vecs[6]  = '{1, 1, 0, 0, 0, 448, 224, 3, 0, 1}; // start in RUN ignored
        vecs[7]  = '{0, 0, 1, 1, 0, 448, 224, 3, 0, 1}; // latch right, no tick
        vecs[8]  = '{0, 1, 0, 0, 0, 464, 224, 3, 0, 1}; // pending right used
        vecs[9]  = '{0, 1, 1, 3, 0, 480, 224, 3, 0, 1}; // reversal again
        vecs[10] = '{0, 0, 0, 0, 1, 480, 224, 3, 0, 1}; // grow without tick
        vecs[11] = '{0, 1, 0, 0, 0, 496, 224, 4, 0, 1}; // pending growth

        reset_game_n = 1'b0;
        idle_inputs();
        model_init();
        #30;
        check("por.head_y", 32'(snake_y[0]), 256);
        check("por.seg1_x", 32'(snake_x[1]), 384);
        check("por.game_over", 32'(game_over), 0);
        check("por.len", 32'(snake_length), 2);
        #20;
        reset_game_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].s, vecs[i].mt, vecs[i].dv, vecs[i].dr, vecs[i].g);
            check($sformatf("vec%0d.head_x", i), 32'(snake_x[0]), vecs[i].hx);
            check($sformatf("vec%0d.head_y", i), 32'(snake_y[0]), vecs[i].hy);
            check($sformatf("vec%0d.len", i), 32'(snake_length), vecs[i].len);
            check($sformatf("vec%0d.game_over", i), 32'(game_over), 32'(vecs[i].go));
            check($sformatf("vec%0d.running", i), 32'(running), 32'(vecs[i].run));
        end

        // Growth saturation, then wall collision and re-init.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 0, 0, 1);
            if (k == 0)
                check("grow.seg3_old_seg2", 32'(snake_x[3]), 368);
            check($sformatf("grow%0d.len", k), 32'(snake_length),
                  (k + 3 > 15) ? 15 : k + 3);
        end
        check("grow.head_x", 32'(snake_x[0]), 720);
        for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0);
        check("wall.edge_x", 32'(snake_x[0]), 768);
        check("wall.edge_go", 32'(game_over), 0);
        cycle(0, 1, 0, 0, 0);
        check("wall.game_over", 32'(game_over), 1);
        check("wall.running", 32'(running), 0);
        check("wall.head_x", 32'(snake_x[0]), 768);
        check("wall.seg1_x", 32'(snake_x[1]), 752);
        check("wall.len", 32'(snake_length), 15);
        cycle(0, 1, 1, 2, 1);
        cycle(0, 1, 0, 0, 0);
        check("dead.head_x", 32'(snake_x[0]), 768);
        check("dead.head_y", 32'(snake_y[0]), 256);
        check("dead.len", 32'(snake_length), 15);
        cycle(1, 0, 0, 0, 0);
        check("restart.head_x", 32'(snake_x[0]), 400);
        check("restart.seg2_x", 32'(snake_x[2]), 368);
        check("restart.seg3_x", 32'(snake_x[3]), 0);
        check("restart.len", 32'(snake_length), 2);
        check("restart.game_over", 32'(game_over), 0);
        check("restart.running", 32'(running), 0);

        // Self collision: length 5, then up, left, down.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 1);
        check("self.len", 32'(snake_length), 4);
        cycle(0, 1, 1, 0, 0);
        check("self.up_y", 32'(snake_y[0]), 240);
        check("self.up_x", 32'(snake_x[0]), 432);
        cycle(0, 1, 1, 3, 0);
        check("self.left_x", 32'(snake_x[0]), 416);
        check("self.left_go", 32'(game_over), 0);
        cycle(0, 1, 1, 2, 0);
        check("self.game_over", 32'(game_over), 1);
        check("self.head_x", 32'(snake_x[0]), 416);
        check("self.head_y", 32'(snake_y[0]), 240);

        // Asynchronous reset in the middle of RUN.
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        cycle(0, 1, 1, 2, 0);
        idle_inputs();
        #5;
        reset_game_n = 1'b0;
        model_init();
        #1;
        check("async.head_x", 32'(snake_x[0]), 400);
        check("async.head_y", 32'(snake_y[0]), 256);
        check("async.seg1_x", 32'(snake_x[1]), 384);
        check("async.len", 32'(snake_length), 2);
        check("async.running", 32'(running), 0);
        #5;
        reset_game_n = 1'b1;
        cycle(0, 0, 0, 0, 0);

        // Randomized run against the model.
        cycle(1, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 3) == 0);
        end

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
